// File: rtl/dpram_pkg.sv
// dpram_pkg: shared constants and helpers for dual_port_ram_param.
//   RDW_READ_FIRST / RDW_WRITE_FIRST : same-address read-during-write policy codes.
//   byte_merge(old, new, be)         : word whose enabled bytes come from new and
//                                      the others from old. Operates on a wide
//                                      container; callers size-cast in and out.
package dpram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest word byte_merge handles; narrower words are zero-extended on entry.
    localparam int MERGE_MAX_W  = 1024;
    localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

    typedef logic [MERGE_MAX_W-1:0]  merge_word_t;
    typedef logic [MERGE_MAX_BE-1:0] merge_be_t;

    function automatic merge_word_t byte_merge(input merge_word_t old_w,
                                               input merge_word_t new_w,
                                               input merge_be_t   be);
        merge_word_t res;
        res = old_w;
        for (int i = 0; i < MERGE_MAX_BE; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dpram_out_stage.sv
// dpram_out_stage: optional output pipeline register for the RAM read path.
//   clk, rst_n      : clock, asynchronous active-low clear
//   valid_i/valid_o : read-valid strobe in / delayed by one edge
//   data_i/data_o   : read data in / out; out holds when no valid read passes
//   coll_i/coll_o   : collision flag in / delayed by one edge
module dpram_out_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              coll_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              coll_o
);

    logic              valid_q;
    logic              coll_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Data only moves with a valid read so the output holds between reads.
    assign data_d = valid_i ? data_i : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            coll_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            coll_q  <= coll_i;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign coll_o  = coll_q;

endmodule

// File: rtl/dual_port_ram_param.sv
// dual_port_ram_param: simple dual-port synchronous RAM, one write + one read port.
//   clk, rst_n        : clock, asynchronous active-low reset (memory contents kept)
//   cs                : chip select, gates both ports
//   write_en/addr/data/be : write request with per-byte enables
//   read_en/read_addr : read request
//   read_data         : read result, holds between reads
//   read_valid        : one-cycle strobe qualifying read_data (latency 1 or 2)
//   collision         : with read_valid, read hit the address written that cycle
//   addr_err          : one-cycle pulse one edge after an out-of-range access
module dual_port_ram_param
    import dpram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int BE_W     = DATA_W / 8,
    parameter int RDW_MODE = RDW_READ_FIRST,
    parameter int OUT_REG  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [BE_W-1:0]   write_be,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] read_data,
    output logic              read_valid,
    output logic              collision,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wr_acc, rd_acc, wr_ok, rd_ok, rd_hit;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [DATA_W-1:0] rd_old, rd_merged;

    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              rd_valid_d, rd_valid_q;
    logic              coll_d, coll_q;
    logic              err_d, err_q;

    assign wr_acc = cs && write_en;
    assign rd_acc = cs && read_en;
    assign wr_ok  = {1'b0, write_addr} < DEPTH_A;
    assign rd_ok  = {1'b0, read_addr}  < DEPTH_A;
    assign wr_idx = write_addr[IDX_W-1:0];
    assign rd_idx = read_addr[IDX_W-1:0];

    // A zero byte mask writes nothing, so it cannot collide.
    assign rd_hit = wr_acc && rd_acc && wr_ok && rd_ok &&
                    (write_addr == read_addr) && (write_be != '0);

    // Memory: no reset on the array, but writes are blocked while rst_n is low.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc && wr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (write_be[b]) mem_q[wr_idx][8*b +: 8] <= write_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        rd_old    = mem_q[rd_idx];
        rd_merged = DATA_W'(byte_merge(merge_word_t'(rd_old),
                                       merge_word_t'(write_data),
                                       merge_be_t'(write_be)));
        rd_data_d = rd_data_q;
        if (rd_acc) begin
            if (!rd_ok)
                rd_data_d = '0;
            else if (RDW_MODE == RDW_WRITE_FIRST && rd_hit)
                rd_data_d = rd_merged;
            else
                rd_data_d = rd_old;
        end
        rd_valid_d = rd_acc;
        coll_d     = rd_hit;
        // Read and write range errors in one cycle fold into a single pulse.
        err_d      = (rd_acc && !rd_ok) || (wr_acc && !wr_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            coll_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            coll_q     <= coll_d;
            err_q      <= err_d;
        end
    end

    // addr_err also covers writes, so it is not delayed by the output stage.
    assign addr_err = err_q;

    if (OUT_REG != 0) begin : g_out_reg
        dpram_out_stage #(.DATA_W(DATA_W)) u_out_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (rd_valid_q),
            .data_i  (rd_data_q),
            .coll_i  (coll_q),
            .valid_o (read_valid),
            .data_o  (read_data),
            .coll_o  (collision)
        );
    end else begin : g_no_out_reg
        assign read_valid = rd_valid_q;
        assign read_data  = rd_data_q;
        assign collision  = coll_q;
    end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Bench for dual_port_ram_param. Three instances share one stimulus stream:
//   u_a: 32-bit, DEPTH 200, read-first, latency 1
//   u_b: 32-bit, DEPTH 200, write-first, latency 2
//   u_c: defaults (8-bit x 256, read-first, latency 1), fed the low data byte
// Expected reads are queued with the cycle they must appear in.
module tb_dual_port_ram_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cs, we, re;
    logic [7:0]  wa, ra;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] a_rd, b_rd;
    logic [7:0]  c_rd;
    logic        a_v, a_c, a_e, b_v, b_c, b_e, c_v, c_c, c_e;

    dual_port_ram_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RDW_MODE(0), .OUT_REG(0)) u_a (
        .clk(clk), .rst_n(rst_n), .cs(cs), .write_en(we), .write_addr(wa), .write_data(wd),
        .write_be(be), .read_en(re), .read_addr(ra), .read_data(a_rd), .read_valid(a_v),
        .collision(a_c), .addr_err(a_e));

    dual_port_ram_param #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RDW_MODE(1), .OUT_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .cs(cs), .write_en(we), .write_addr(wa), .write_data(wd),
        .write_be(be), .read_en(re), .read_addr(ra), .read_data(b_rd), .read_valid(b_v),
        .collision(b_c), .addr_err(b_e));

    dual_port_ram_param u_c (
        .clk(clk), .rst_n(rst_n), .cs(cs), .write_en(we), .write_addr(wa), .write_data(wd[7:0]),
        .write_be(be[0:0]), .read_en(re), .read_addr(ra), .read_data(c_rd), .read_valid(c_v),
        .collision(c_c), .addr_err(c_e));

    typedef struct { logic [31:0] d; logic c; int due; } exp_t;
    typedef struct {
        logic cs, we; logic [7:0] wa; logic [31:0] wd; logic [3:0] be; logic re; logic [7:0] ra;
        logic ev; logic [31:0] ed; logic ec, ee;
    } vec_t;

    exp_t        qa[$], qb[$], qc[$];
    logic [31:0] ma [256];
    logic [7:0]  mc [256];
    logic [31:0] last_a, last_b, last_c;
    logic        ee_a, ee_b, ee_c;
    int          nchk = 0, nerr = 0, cyc = 0;
    vec_t        nov;
    vec_t        tbl [19];

    always @(posedge clk) cyc++;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk(input string nm, input bit ev, input exp_t e, input logic v,
                       input logic [31:0] d, input logic c, inout logic [31:0] last);
        cmp({nm, ".read_valid"}, 32'(v), 32'(ev));
        if (ev) begin
            cmp({nm, ".read_data"}, d, e.d);
            cmp({nm, ".collision"}, 32'(c), 32'(e.c));
            last = e.d;
        end else begin
            cmp({nm, ".read_data_hold"}, d, last);
            cmp({nm, ".collision_idle"}, 32'(c), 32'd0);
        end
    endtask

    task automatic check_all();
        exp_t e;
        bit   ev;
        ev = 0; if (qa.size() > 0) ev = (qa[0].due == cyc);
        if (ev) e = qa.pop_front();
        chk("A", ev, e, a_v, a_rd, a_c, last_a);
        cmp("A.addr_err", 32'(a_e), 32'(ee_a));
        ev = 0; if (qb.size() > 0) ev = (qb[0].due == cyc);
        if (ev) e = qb.pop_front();
        chk("B", ev, e, b_v, b_rd, b_c, last_b);
        cmp("B.addr_err", 32'(b_e), 32'(ee_b));
        ev = 0; if (qc.size() > 0) ev = (qc[0].due == cyc);
        if (ev) e = qc.pop_front();
        chk("C", ev, e, c_v, 32'(c_rd), c_c, last_c);
        cmp("C.addr_err", 32'(c_e), 32'(ee_c));
    endtask

    task automatic check_zero(input string nm);
        cmp({nm, ".A.outs"}, {a_rd[30:0], a_v | a_c | a_e}, 32'd0);
        cmp({nm, ".B.outs"}, {b_rd[30:0], b_v | b_c | b_e}, 32'd0);
        cmp({nm, ".C.outs"}, {23'd0, c_rd, c_v | c_c | c_e}, 32'd0);
        cmp({nm, ".A.msb"}, {31'd0, a_rd[31] | b_rd[31]}, 32'd0);
    endtask

    // Drive one cycle, queue the expectations, advance the model, then check.
    // With tab set, u_a's expectations come from the table record.
    task automatic step(input logic s_cs, input logic s_we, input logic [7:0] s_wa,
                        input logic [31:0] s_wd, input logic [3:0] s_be, input logic s_re,
                        input logic [7:0] s_ra, input bit tab, input vec_t tv);
        logic wacc, racc, wok, rok, hit, hit_c;
        logic [31:0] old, mrg;
        exp_t e;
        cs = s_cs; we = s_we; wa = s_wa; wd = s_wd; be = s_be; re = s_re; ra = s_ra;
        wacc  = rst_n && s_cs && s_we;
        racc  = rst_n && s_cs && s_re;
        wok   = s_wa < 8'd200;
        rok   = s_ra < 8'd200;
        hit   = wacc && racc && wok && rok && (s_wa == s_ra) && (s_be != 4'd0);
        hit_c = wacc && racc && (s_wa == s_ra) && s_be[0];
        old   = rok ? ma[s_ra] : 32'd0;
        mrg   = old;
        for (int i = 0; i < 4; i++) if (s_be[i]) mrg[8*i +: 8] = s_wd[8*i +: 8];
        if (tab) begin
            if (tv.ev) begin e.d = tv.ed; e.c = tv.ec; e.due = cyc + 1; qa.push_back(e); end
            ee_a = tv.ee;
        end else begin
            if (racc) begin e.d = old; e.c = hit; e.due = cyc + 1; qa.push_back(e); end
            ee_a = (racc && !rok) || (wacc && !wok);
        end
        if (racc) begin e.d = hit ? mrg : old; e.c = hit; e.due = cyc + 2; qb.push_back(e); end
        if (racc) begin e.d = 32'(mc[s_ra]); e.c = hit_c; e.due = cyc + 1; qc.push_back(e); end
        ee_b = (racc && !rok) || (wacc && !wok);
        ee_c = 1'b0;
        if (wacc && wok)
            for (int i = 0; i < 4; i++) if (s_be[i]) ma[s_wa][8*i +: 8] = s_wd[8*i +: 8];
        if (wacc && s_be[0]) mc[s_wa] = s_wd[7:0];
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic hs(input logic s_cs, input logic s_we, input logic [7:0] s_wa,
                      input logic [31:0] s_wd, input logic [3:0] s_be, input logic s_re,
                      input logic [7:0] s_ra);
        step(s_cs, s_we, s_wa, s_wd, s_be, s_re, s_ra, 1'b0, nov);
    endtask

    function automatic vec_t mk(input logic c, input logic w, input logic [7:0] a,
                                input logic [31:0] d, input logic [3:0] b, input logic r,
                                input logic [7:0] x, input logic ev, input logic [31:0] ed,
                                input logic ec, input logic ee);
        vec_t v;
        v.cs = c; v.we = w; v.wa = a; v.wd = d; v.be = b; v.re = r; v.ra = x;
        v.ev = ev; v.ed = ed; v.ec = ec; v.ee = ee;
        return v;
    endfunction

    initial begin
        //            cs we wa   wd             be    re ra   ev ed             ec ee
        tbl[0]  = mk(1, 1, 1,   32'd100,       4'hF, 0, 0,   0, 32'd0,        0, 0);
        tbl[1]  = mk(1, 1, 2,   32'd101,       4'hF, 1, 1,   1, 32'd100,      0, 0);
        tbl[2]  = mk(1, 0, 0,   32'd0,         4'h0, 1, 2,   1, 32'd101,      0, 0);
        tbl[3]  = mk(1, 1, 5,   32'hAABBCCDD,  4'hF, 0, 0,   0, 32'd0,        0, 0);
        tbl[4]  = mk(1, 1, 5,   32'h11223344,  4'h5, 0, 0,   0, 32'd0,        0, 0);
        tbl[5]  = mk(1, 0, 0,   32'd0,         4'h0, 1, 5,   1, 32'hAA22CC44, 0, 0);
        tbl[6]  = mk(1, 1, 7,   32'h10,        4'hF, 0, 0,   0, 32'd0,        0, 0);
        tbl[7]  = mk(1, 1, 7,   32'h20,        4'h1, 1, 7,   1, 32'h10,       1, 0);
        tbl[8]  = mk(1, 0, 0,   32'd0,         4'h0, 1, 7,   1, 32'h20,       0, 0);
        tbl[9]  = mk(1, 1, 250, 32'hDEAD,      4'hF, 0, 0,   0, 32'd0,        0, 1);
        tbl[10] = mk(1, 0, 0,   32'd0,         4'h0, 1, 250, 1, 32'd0,        0, 1);
        tbl[11] = mk(1, 1, 199, 32'h12345678,  4'hF, 0, 0,   0, 32'd0,        0, 0);
        tbl[12] = mk(1, 0, 0,   32'd0,         4'h0, 1, 199, 1, 32'h12345678, 0, 0);
        tbl[13] = mk(1, 1, 1,   32'hFF,        4'h0, 1, 1,   1, 32'd100,      0, 0);
        tbl[14] = mk(0, 1, 1,   32'h55,        4'hF, 1, 1,   0, 32'd0,        0, 0);
        tbl[15] = mk(1, 0, 0,   32'd0,         4'h0, 1, 1,   1, 32'd100,      0, 0);
        tbl[16] = mk(1, 1, 251, 32'h99,        4'hF, 1, 250, 1, 32'd0,        0, 1);
        tbl[17] = mk(1, 1, 200, 32'h77,        4'hF, 0, 0,   0, 32'd0,        0, 1);
        tbl[18] = mk(1, 0, 0,   32'd0,         4'h0, 1, 200, 1, 32'd0,        0, 1);
        nov = mk(0, 0, 0, 32'd0, 4'h0, 0, 0, 0, 32'd0, 0, 0);

        rst_n = 1'b0; cs = 0; we = 0; re = 0; wa = 0; ra = 0; wd = 0; be = 0;
        last_a = 0; last_b = 0; last_c = 0; ee_a = 0; ee_b = 0; ee_c = 0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        foreach (tbl[i])
            step(tbl[i].cs, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].be, tbl[i].re, tbl[i].ra,
                 1'b1, tbl[i]);
        hs(0, 0, 0, 0, 0, 0, 0);

        // Latency 2 on u_b, then deselected reads: no valid, data holds 100.
        hs(1, 0, 0, 0, 0, 1, 1);
        hs(0, 0, 0, 0, 0, 1, 1);
        hs(0, 0, 0, 0, 0, 1, 1);

        // Reset between accept and the second edge drops u_b's read.
        hs(1, 0, 0, 0, 0, 1, 1);
        #1 rst_n = 1'b0;
        #1 check_zero("reset_mid");
        qa.delete(); qb.delete(); qc.delete();
        last_a = 0; last_b = 0; last_c = 0; ee_a = 0; ee_b = 0; ee_c = 0;
        hs(1, 1, 1, 32'hEE, 4'hF, 1, 1);   // write blocked while in reset
        rst_n = 1'b1;
        hs(0, 0, 0, 0, 0, 0, 0);
        hs(0, 0, 0, 0, 0, 0, 0);
        hs(1, 0, 0, 0, 0, 1, 1);           // memory retained: 100
        hs(0, 0, 0, 0, 0, 0, 0);
        hs(0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_param.md
Name:
dual_port_ram_param

Overview:
- Parametrised simple dual-port synchronous RAM: one write port and one read port, sharing a single clock.
- Generalises the fixed 8-bit x 256 dual_RAM. Adds configurable width and depth, per-byte write enables, a selectable read-during-write policy, an optional output register, a read-valid strobe and collision/address-error flags.
- Serves as the storage primitive under register files, FIFOs and scratchpads in the Computer_Architecture designs.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_W.
- BE_W, DATA_W/8, number of byte-enable bits (derived; do not override).
- RDW_MODE, 0, same-address read-during-write policy: 0 = read-first (old data), 1 = write-first (new data).
- OUT_REG, 0, 1 adds an output pipeline register, making read latency 2.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- cs, input, 1, chip select; gates both ports.
- write_en, input, 1, write request.
- write_addr, input, ADDR_W, write address.
- write_data, input, DATA_W, write data.
- write_be, input, BE_W, byte enables; bit i covers write_data[8i+7:8i].
- read_en, input, 1, read request.
- read_addr, input, ADDR_W, read address.
- read_data, output, DATA_W, read data.
- read_valid, output, 1, one-cycle pulse qualifying read_data.
- collision, output, 1, pulse aligned with read_valid: the read hit an address written in the same cycle.
- addr_err, output, 1, one-cycle pulse: an accepted write or read had address >= DEPTH.

Behaviour:
- Reset: while rst_n is low, read_data = 0, read_valid = 0, collision = 0, addr_err = 0, and all pipeline registers are cleared.
- Memory contents are not cleared by reset. Writes are suppressed while rst_n is low.
- Write: on a rising edge with cs && write_en && write_addr < DEPTH, mem[write_addr] byte i <= write_data byte i for each write_be[i] = 1. Other bytes are unchanged.
- write_be = 0 performs no write and is not an error.
- Read accept: cs && read_en on a rising edge.
  - OUT_REG=0: read_data and read_valid update on that same edge (latency 1).
  - OUT_REG=1: read_data and read_valid update one edge later (latency 2).
- Out-of-range read: returns 0 with read_valid = 1 and addr_err pulsed.
- Out-of-range write: ignored, with addr_err pulsed.
- A single addr_err pulse covers both out-of-range cases occurring in the same cycle.
- No read accepted: read_valid = 0 and read_data holds its last value; it is never cleared to 0 except by reset.
- cs = 0: both ports idle and no flags are raised. The pipeline still advances, so an in-flight OUT_REG read completes.
- Same-address read and write (both accepted, address < DEPTH, write_be != 0):
  - collision is set in the read's valid cycle.
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns the byte-merge (enabled bytes from write_data, the rest from the old word).
- Reset asserted mid-operation: in-flight reads are dropped with no read_valid afterwards. Reads resume on the first accepted read after rst_n rises.
- Address arithmetic: no wrap. Addresses >= DEPTH are errors, not aliases.

Decomposition:
- Shared package dpram_pkg holds:
  - RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1 constants;
  - a byte-merge function (old, new, be) -> merged word.
- One natural sub-module: dpram_out_stage. It is the optional OUT_REG pipeline register for read_data, read_valid and collision, with asynchronous clear. It is instantiated only when OUT_REG = 1.

Test Plan:
- Basic write/read (defaults): write 100 to [1], then 101 to [2] while reading [1] -> read_data = 100, read_valid = 1, collision = 0. A following read of [2] -> 101.
- Byte enables (DATA_W=32): write 0xAABBCCDD to [5] with be = 1111, then 0x11223344 with be = 0101 -> read [5] = 0xAA22CC44.
- RDW collision at [7] (old 0x10, write 0x20 with be = 1, read [7] in the same cycle):
  - RDW_MODE=0 -> read_data = 0x10, collision = 1;
  - RDW_MODE=1 -> 0x20, collision = 1.
- Latency/idle: with OUT_REG=1, read [1] -> read_valid rises exactly 2 edges after accept. Then cs = 0 with read_en = 1 -> read_valid stays 0 and read_data holds 100.
- Error/boundary (DEPTH=200, ADDR_W=8): write to [250] -> addr_err pulse, memory unchanged. Read [250] -> read_data = 0, read_valid = 1, addr_err = 1. Read [199] -> stored value, no error.
- Reset mid-operation (OUT_REG=1): accept read [1], pull rst_n low before the second edge -> outputs 0 immediately, no read_valid after release. Memory still holds [1] = 100 on the next read.
